pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage 8-bit pipeline (IF, ID, EX, MEM, WB). It drives the enable and flush of the PC and every stage register (IF_ID, ID_EX, EX_MEM, MEM_WB). It also generates the EX-stage forwarding selects and freezes the pipeline while data memory is busy. It additionally maintains a saturating stall counter and a sticky memory-timeout flag for debug.

Parameters:
- REG_W, 3, register-index width (8 architectural registers)
- MEM_TIMEOUT, 64, MEM_WAIT cycles before timeout_o sets; range 1..255
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_reg1_i  in  REG_W  source register 1 of the instruction in ID
- id_reg2_i  in  REG_W  source register 2 of the instruction in ID
- id_uses2_i  in  1  ID instruction reads reg2
- ex_dst_i  in  REG_W  destination register of the instruction in EX
- ex_writeReg_i  in  1  EX instruction writes the register file
- ex_is_load_i  in  1  EX instruction is a load
- ex_src1_i  in  REG_W  operand register 1 of the EX instruction (forwarding)
- ex_src2_i  in  REG_W  operand register 2 of the EX instruction (forwarding)
- mem_dst_i  in  REG_W  destination register held in EX_MEM
- mem_writeReg_i  in  1  EX_MEM writeReg
- wb_dst_i  in  REG_W  destination register held in MEM_WB
- wb_writeReg_i  in  1  MEM_WB writeReg
- branch_taken_i  in  1  EX resolved a taken branch or jump
- mem_req_i  in  1  MEM stage is accessing data memory
- mem_ready_i  in  1  data memory completes the access this cycle
- pc_en_o  out  1  PC update enable
- if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  stage-register load enables
- if_id_flush_o, id_ex_flush_o  out  1 each  load a bubble (writeReg=0, opcode NOP)
- fwd_a_o, fwd_b_o  out  2 each  EX operand select: 00 regfile, 01 EX_MEM, 10 MEM_WB
- stall_cnt_o  out  CNT_W  count of non-RUN-advance cycles, saturating
- timeout_o  out  1  sticky memory-timeout flag

Behaviour:
- FSM states: RUN, MEM_WAIT. The state and the wait counter (8-bit) are registered. Enables and flushes are combinational from state and inputs.
- Reset asserted: next state is RUN, wait counter 0, stall_cnt_o 0, timeout_o 0. While reset is high, all enables are 0, both flushes are 1, and fwd are 00. Reset mid-MEM_WAIT abandons the wait.
- Priority per cycle, highest first: memory wait, branch flush, load-use stall, normal advance.
- Memory wait: mem_req_i & ~mem_ready_i means the state is (or becomes) MEM_WAIT. All enables are 0 and flushes are 0; the pipeline is frozen, including a pending branch, which is handled after release. When mem_ready_i is seen, that cycle advances normally and the state returns to RUN. A request with mem_ready_i in the same cycle costs zero stall.
- MEM_WAIT counter: increments each wait cycle and clears on exit. When it reaches MEM_TIMEOUT, timeout_o sets and stays set until reset. The FSM keeps waiting; no abort.
- Branch (not frozen): pc_en, all stage enables, if_id_flush and id_ex_flush are all 1 for exactly one cycle. The flush wins over a simultaneous load-use stall, because the stalled instruction is squashed.
- Load-use: ex_is_load_i & ex_writeReg_i & (ex_dst_i==id_reg1_i | (id_uses2_i & ex_dst_i==id_reg2_i)). Outputs: pc_en=0, if_id_en=0, id_ex_flush=1, and the remaining enables are 1. This gives a one-cycle bubble; the hazard clears naturally next cycle.
- Normal operation: all enables are 1 and flushes are 0.
- Forwarding (combinational, valid every cycle):
  - fwd_a=01 if mem_writeReg_i & mem_dst_i==ex_src1_i.
  - Else fwd_a=10 if wb_writeReg_i & wb_dst_i==ex_src1_i.
  - Else fwd_a=00.
  - EX_MEM beats MEM_WB. fwd_b is the same using ex_src2_i.
  - Register 0 is not special-cased.
- stall_cnt_o increments by 1 in any cycle with pc_en_o=0 (outside reset) and saturates at all-ones.

Decomposition:
- Package pipeline_pkg holds:
  - the fwd_sel_t enum (FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10);
  - the ctrl_state_t enum (RUN, MEM_WAIT);
  - the NOP opcode constant (4'h0) used by the stage registers on flush.
- One sub-module, fwd_unit: purely combinational forwarding compare, instantiated once, computing both fwd_a and fwd_b.

Test Plan:
- Load-use: ex_is_load=1, ex_writeReg=1, ex_dst=3, id_reg1=3 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1; stall_cnt=1.
- Double forward: mem_dst=2, wb_dst=2, both writeReg=1, ex_src1=2, ex_src2=5 -> fwd_a=01, fwd_b=00. Then set mem_writeReg=0 -> fwd_a=10.
- Branch plus load-use in the same cycle -> both flushes=1, pc_en=1, all enables 1, for exactly one cycle.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 -> 4 frozen cycles with all enables 0, the 5th cycle advances, state returns to RUN, stall_cnt=4.
- Timeout: MEM_TIMEOUT=8, hold mem_ready=0 for 10 cycles -> timeout_o rises after the 8th wait cycle and stays 1 after ready. Reset asserted mid-wait -> next cycle state RUN, timeout_o=0, stall_cnt=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline controller and its stage registers.
package pipeline_pkg;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } ctrl_state_t;

   localparam logic [3:0] NOP_OPCODE = 4'h0;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding compare; the younger EX_MEM result beats MEM_WB.
module fwd_unit
   import pipeline_pkg::*;
#(
   parameter int REG_W = 3
) (
   input  logic [REG_W-1:0] ex_src1_i,
   input  logic [REG_W-1:0] ex_src2_i,
   input  logic [REG_W-1:0] mem_dst_i,
   input  logic             mem_writeReg_i,
   input  logic [REG_W-1:0] wb_dst_i,
   input  logic             wb_writeReg_i,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o
);

   function automatic fwd_sel_t pick(input logic [REG_W-1:0] src);
      fwd_sel_t sel;
      sel = FWD_RF;
      if (mem_writeReg_i && (mem_dst_i == src)) begin
         sel = FWD_EXMEM;
      end else if (wb_writeReg_i && (wb_dst_i == src)) begin
         sel = FWD_MEMWB;
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a_o = pick(ex_src1_i);
      fwd_b_o = pick(ex_src2_i);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: stage enables/flushes, forwarding selects,
// memory-wait freeze with sticky timeout, and a saturating stall counter.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int REG_W       = 3,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_reg1_i,
   input  logic [REG_W-1:0] id_reg2_i,
   input  logic             id_uses2_i,
   input  logic [REG_W-1:0] ex_dst_i,
   input  logic             ex_writeReg_i,
   input  logic             ex_is_load_i,
   input  logic [REG_W-1:0] ex_src1_i,
   input  logic [REG_W-1:0] ex_src2_i,
   input  logic [REG_W-1:0] mem_dst_i,
   input  logic             mem_writeReg_i,
   input  logic [REG_W-1:0] wb_dst_i,
   input  logic             wb_writeReg_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             pc_en_o,
   output logic             if_id_en_o,
   output logic             id_ex_en_o,
   output logic             ex_mem_en_o,
   output logic             mem_wb_en_o,
   output logic             if_id_flush_o,
   output logic             id_ex_flush_o,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             timeout_o
);

   localparam logic [7:0]       TIMEOUT_CNT = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   ctrl_state_t      state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             timeout_q, timeout_d;

   logic [1:0] fwd_a_raw, fwd_b_raw;
   logic       frozen;
   logic       load_use;
   logic [7:0] wait_inc;

   fwd_unit #(.REG_W(REG_W)) u_fwd (
      .ex_src1_i      (ex_src1_i),
      .ex_src2_i      (ex_src2_i),
      .mem_dst_i      (mem_dst_i),
      .mem_writeReg_i (mem_writeReg_i),
      .wb_dst_i       (wb_dst_i),
      .wb_writeReg_i  (wb_writeReg_i),
      .fwd_a_o        (fwd_a_raw),
      .fwd_b_o        (fwd_b_raw)
   );

   always_comb begin
      frozen   = mem_req_i & ~mem_ready_i;
      load_use = ex_is_load_i & ex_writeReg_i &
                 ((ex_dst_i == id_reg1_i) | (id_uses2_i & (ex_dst_i == id_reg2_i)));
      // Wait count after this cycle if it is a wait cycle; holds at 255.
      if (state_q != MEM_WAIT) begin
         wait_inc = 8'd1;
      end else if (wait_cnt_q == 8'hFF) begin
         wait_inc = wait_cnt_q;
      end else begin
         wait_inc = wait_cnt_q + 8'd1;
      end

      pc_en_o       = 1'b1;
      if_id_en_o    = 1'b1;
      id_ex_en_o    = 1'b1;
      ex_mem_en_o   = 1'b1;
      mem_wb_en_o   = 1'b1;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
      fwd_a_o       = fwd_a_raw;
      fwd_b_o       = fwd_b_raw;
      state_d       = RUN;
      wait_cnt_d    = 8'd0;
      timeout_d     = timeout_q;

      if (reset) begin
         {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = 5'b0;
         if_id_flush_o = 1'b1;
         id_ex_flush_o = 1'b1;
         fwd_a_o       = FWD_RF;
         fwd_b_o       = FWD_RF;
         timeout_d     = 1'b0;
      end else if (frozen) begin
         {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = 5'b0;
         state_d    = MEM_WAIT;
         wait_cnt_d = wait_inc;
         if (wait_inc >= TIMEOUT_CNT) begin
            timeout_d = 1'b1;
         end
      end else if (branch_taken_i) begin
         if_id_flush_o = 1'b1;
         id_ex_flush_o = 1'b1;
      end else if (load_use) begin
         pc_en_o       = 1'b0;
         if_id_en_o    = 1'b0;
         id_ex_flush_o = 1'b1;
      end

      stall_cnt_d = stall_cnt_q;
      if (reset) begin
         stall_cnt_d = '0;
      end else if (!pc_en_o && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         wait_cnt_q  <= 8'd0;
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected outputs queued per step, popped and checked mid-cycle.
module tb_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] id_reg1_i, id_reg2_i, ex_dst_i, ex_src1_i, ex_src2_i, mem_dst_i, wb_dst_i;
   logic       id_uses2_i, ex_writeReg_i, ex_is_load_i, mem_writeReg_i, wb_writeReg_i;
   logic       branch_taken_i, mem_req_i, mem_ready_i;
   logic       pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
   logic       if_id_flush_o, id_ex_flush_o;
   logic [1:0] fwd_a_o, fwd_b_o;
   logic [15:0] stall_cnt_o;
   logic       timeout_o;

   typedef struct packed {
      logic       pc;
      logic [3:0] en;
      logic [1:0] fl;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       to;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_stall = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.REG_W(3), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .id_reg1_i      (id_reg1_i),
      .id_reg2_i      (id_reg2_i),
      .id_uses2_i     (id_uses2_i),
      .ex_dst_i       (ex_dst_i),
      .ex_writeReg_i  (ex_writeReg_i),
      .ex_is_load_i   (ex_is_load_i),
      .ex_src1_i      (ex_src1_i),
      .ex_src2_i      (ex_src2_i),
      .mem_dst_i      (mem_dst_i),
      .mem_writeReg_i (mem_writeReg_i),
      .wb_dst_i       (wb_dst_i),
      .wb_writeReg_i  (wb_writeReg_i),
      .branch_taken_i (branch_taken_i),
      .mem_req_i      (mem_req_i),
      .mem_ready_i    (mem_ready_i),
      .pc_en_o        (pc_en_o),
      .if_id_en_o     (if_id_en_o),
      .id_ex_en_o     (id_ex_en_o),
      .ex_mem_en_o    (ex_mem_en_o),
      .mem_wb_en_o    (mem_wb_en_o),
      .if_id_flush_o  (if_id_flush_o),
      .id_ex_flush_o  (id_ex_flush_o),
      .fwd_a_o        (fwd_a_o),
      .fwd_b_o        (fwd_b_o),
      .stall_cnt_o    (stall_cnt_o),
      .timeout_o      (timeout_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      id_reg1_i = 3'd0; id_reg2_i = 3'd0; id_uses2_i = 1'b0;
      ex_dst_i = 3'd7; ex_writeReg_i = 1'b0; ex_is_load_i = 1'b0;
      ex_src1_i = 3'd6; ex_src2_i = 3'd6;
      mem_dst_i = 3'd1; mem_writeReg_i = 1'b0;
      wb_dst_i = 3'd1; wb_writeReg_i = 1'b0;
      branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
   endtask

   // Inputs are already driven; queue the expectation, check mid-cycle, then cross the edge.
   task automatic step(input string tag, input logic pc, input logic [3:0] en,
                       input logic [1:0] fl, input logic [1:0] fa, input logic [1:0] fb,
                       input logic to);
      exp_t e;
      sb.push_back('{pc: pc, en: en, fl: fl, fa: fa, fb: fb, to: to});
      @(negedge clk);
      e = sb.pop_front();
      chk({tag, ".pc_en"}, 32'(pc_en_o), 32'(e.pc));
      chk({tag, ".en"}, 32'({if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o}), 32'(e.en));
      chk({tag, ".flush"}, 32'({if_id_flush_o, id_ex_flush_o}), 32'(e.fl));
      chk({tag, ".fwd_a"}, 32'(fwd_a_o), 32'(e.fa));
      chk({tag, ".fwd_b"}, 32'(fwd_b_o), 32'(e.fb));
      chk({tag, ".timeout"}, 32'(timeout_o), 32'(e.to));
      chk({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(exp_stall));
      @(posedge clk);
      if (reset) exp_stall = 0;
      else if (!e.pc) exp_stall++;
      #1;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step("reset", 1'b0, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0);
      reset = 1'b0;
      step("normal", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);

      ex_is_load_i = 1'b1; ex_writeReg_i = 1'b1; ex_dst_i = 3'd3; id_reg1_i = 3'd3;
      step("lu_reg1", 1'b0, 4'b0111, 2'b01, 2'b00, 2'b00, 1'b0);
      clear_inputs();
      step("lu_after", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);

      ex_is_load_i = 1'b1; ex_writeReg_i = 1'b1; ex_dst_i = 3'd4;
      id_reg1_i = 3'd1; id_reg2_i = 3'd4; id_uses2_i = 1'b1;
      step("lu_reg2", 1'b0, 4'b0111, 2'b01, 2'b00, 2'b00, 1'b0);
      id_uses2_i = 1'b0;
      step("lu_reg2_unused", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
      ex_writeReg_i = 1'b0; id_uses2_i = 1'b1;
      step("lu_nowrite", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
      clear_inputs();

      mem_dst_i = 3'd2; wb_dst_i = 3'd2; mem_writeReg_i = 1'b1; wb_writeReg_i = 1'b1;
      ex_src1_i = 3'd2; ex_src2_i = 3'd5;
      step("fwd_both", 1'b1, 4'b1111, 2'b00, 2'b01, 2'b00, 1'b0);
      mem_writeReg_i = 1'b0;
      step("fwd_wb", 1'b1, 4'b1111, 2'b00, 2'b10, 2'b00, 1'b0);
      mem_writeReg_i = 1'b1; ex_src2_i = 3'd2; wb_dst_i = 3'd5; ex_src1_i = 3'd5;
      step("fwd_split", 1'b1, 4'b1111, 2'b00, 2'b10, 2'b01, 1'b0);
      mem_writeReg_i = 1'b0; wb_dst_i = 3'd0; ex_src1_i = 3'd0; ex_src2_i = 3'd0;
      step("fwd_r0", 1'b1, 4'b1111, 2'b00, 2'b10, 2'b10, 1'b0);
      clear_inputs();

      branch_taken_i = 1'b1;
      ex_is_load_i = 1'b1; ex_writeReg_i = 1'b1; ex_dst_i = 3'd3; id_reg1_i = 3'd3;
      step("br_lu", 1'b1, 4'b1111, 2'b11, 2'b00, 2'b00, 1'b0);
      clear_inputs();
      step("br_after", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);

      mem_req_i = 1'b1; mem_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         branch_taken_i = (i == 1);
         step("mem_frozen", 1'b0, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
      end
      branch_taken_i = 1'b0; mem_ready_i = 1'b1;
      step("mem_release", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
      mem_req_i = 1'b0; mem_ready_i = 1'b0;
      step("mem_idle", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
      mem_req_i = 1'b1; mem_ready_i = 1'b1;
      step("mem_zero_wait", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);

      mem_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step("to_wait", 1'b0, 4'b0000, 2'b00, 2'b00, 2'b00, (i >= 8));
      end
      mem_ready_i = 1'b1;
      step("to_release", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b1);
      mem_req_i = 1'b0;
      step("to_sticky", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b1);

      mem_req_i = 1'b1; mem_ready_i = 1'b0;
      step("rst_wait", 1'b0, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1);
      reset = 1'b1;
      mem_dst_i = 3'd6; mem_writeReg_i = 1'b1;
      step("rst_mid", 1'b0, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b1);
      reset = 1'b0;
      clear_inputs();
      step("rst_done", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);

      mem_req_i = 1'b1; mem_ready_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step("short_wait", 1'b0, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
      end
      mem_ready_i = 1'b1;
      step("short_release", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
      clear_inputs();
      step("final", 1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
